// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage_if
// Description : Bundles the execute-side and memory-side handshake/data
//               signals of the EX/MEM pipeline stage. The 'slave' modport is
//               the stage's view; the 'master' modport is the surrounding
//               pipeline (execute, memory, hazard/forwarding logic).
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_stage_if #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3
);

  // Pipeline control
  logic             flush;

  // Execute -> stage
  logic             ex_valid;
  logic             ex_ready;
  logic [WIDTH-1:0] alu_out;
  logic             alu_msb;
  logic             alu_zero;
  logic [2:0]       br_cond;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] st_data;
  logic             mem_rd;
  logic             mem_wr;
  logic             rf_we;
  logic             halt;
  logic [REGW-1:0]  rf_wsel;

  // Stage -> memory
  logic             mem_valid;
  logic             mem_ready;
  logic [WIDTH-1:0] m_alu_out;
  logic [WIDTH-1:0] m_st_data;
  logic             m_mem_rd;
  logic             m_mem_wr;
  logic             m_rf_we;
  logic             m_halt;
  logic [REGW-1:0]  m_rf_wsel;

  // Stage -> fetch (branch redirect)
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;

  // Stage -> decode (operand bypass)
  logic             fwd_valid;
  logic [REGW-1:0]  fwd_wsel;
  logic [WIDTH-1:0] fwd_data;

  modport master (
    output flush,
    output ex_valid, alu_out, alu_msb, alu_zero, br_cond, br_target,
    output st_data, mem_rd, mem_wr, rf_we, halt, rf_wsel,
    output mem_ready,
    input  ex_ready,
    input  mem_valid, m_alu_out, m_st_data, m_mem_rd, m_mem_wr, m_rf_we,
    input  m_halt, m_rf_wsel,
    input  redirect, redirect_pc,
    input  fwd_valid, fwd_wsel, fwd_data
  );

  modport slave (
    input  flush,
    input  ex_valid, alu_out, alu_msb, alu_zero, br_cond, br_target,
    input  st_data, mem_rd, mem_wr, rf_we, halt, rf_wsel,
    input  mem_ready,
    output ex_ready,
    output mem_valid, m_alu_out, m_st_data, m_mem_rd, m_mem_wr, m_rf_we,
    output m_halt, m_rf_wsel,
    output redirect, redirect_pc,
    output fwd_valid, fwd_wsel, fwd_data
  );

endinterface
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register with a 2-entry skid buffer
//               (main + skid) and valid/ready handshakes on both sides.
//               Resolves conditional branches from the ALU MSB/Zero flags at
//               accept time and issues a one-cycle fetch redirect; entries
//               accepted while that redirect is high are wrong-path and are
//               consumed but discarded.
//               Optional operand bypass from the main register is enabled by
//               defining the macro EXMEM_FWD_EN; otherwise fwd_* are tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  ex_mem_stage_if.slave bus
);

  // Buffer occupancy
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Branch condition encodings
  localparam logic [2:0] BR_BEQZ = 3'b001;
  localparam logic [2:0] BR_BNEZ = 3'b010;
  localparam logic [2:0] BR_BLTZ = 3'b011;
  localparam logic [2:0] BR_BGEZ = 3'b100;
  localparam logic [2:0] BR_JUMP = 3'b101;

  typedef struct packed {
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] st_data;
    logic             mem_rd;
    logic             mem_wr;
    logic             rf_we;
    logic             halt;
    logic [REGW-1:0]  rf_wsel;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '0;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  entry_t           main_q;
  entry_t           skid_q;
  entry_t           in_entry;
  logic             redirect_q;
  logic [WIDTH-1:0] redirect_pc_q;

  // Handshake / load-control signals produced by the output decode
  logic ex_ready_w;
  logic mem_valid_w;
  logic accept;
  logic retire;
  logic store;
  logic load_main_ex;
  logic load_main_skid;
  logic load_skid;
  logic taken;

  assign in_entry.alu_out = bus.alu_out;
  assign in_entry.st_data = bus.st_data;
  assign in_entry.mem_rd  = bus.mem_rd;
  assign in_entry.mem_wr  = bus.mem_wr;
  assign in_entry.rf_we   = bus.rf_we;
  assign in_entry.halt    = bus.halt;
  assign in_entry.rf_wsel = bus.rf_wsel;

  // Branch decision from the ALU flags of the incoming entry
  always_comb begin
    taken = 1'b0;
    case (bus.br_cond)
      BR_BEQZ: taken = bus.alu_zero;
      BR_BNEZ: taken = ~bus.alu_zero;
      BR_BLTZ: taken = bus.alu_msb;
      BR_BGEZ: taken = ~bus.alu_msb;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy; flush overrides any handshake in the same cycle
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (store) state_d = ST_ONE;
        ST_ONE: begin
          if (store && !retire)      state_d = ST_FULL;
          else if (!store && retire) state_d = ST_EMPTY;
          else                       state_d = ST_ONE;
        end
        ST_FULL:  if (retire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake and buffer load enables decoded from the current occupancy.
  // ex_ready depends only on state_q, so memory backpressure never reaches
  // execute combinationally. Wrong-path entries (redirect high) complete the
  // handshake but are not stored.
  always_comb begin
    ex_ready_w     = (state_q != ST_FULL);
    mem_valid_w    = (state_q == ST_ONE) || (state_q == ST_FULL);
    accept         = bus.ex_valid && ex_ready_w;
    retire         = mem_valid_w && bus.mem_ready;
    store          = accept && !redirect_q && !bus.flush;
    load_main_ex   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!bus.flush) begin
      case (state_q)
        ST_EMPTY: load_main_ex = store;
        ST_ONE: begin
          load_main_ex = store && retire;
          load_skid    = store && !retire;
        end
        ST_FULL:  load_main_skid = retire;
        default: begin
          load_main_ex   = 1'b0;
          load_main_skid = 1'b0;
          load_skid      = 1'b0;
        end
      endcase
    end
  end

  // Main (head) and skid data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= ENTRY_ZERO;
      skid_q <= ENTRY_ZERO;
    end else begin
      if (load_main_ex) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  // One-cycle redirect pulse for a stored taken branch; target held after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= store && taken;
      if (store && taken) begin
        redirect_pc_q <= bus.br_target;
      end
    end
  end

  assign bus.ex_ready    = ex_ready_w;
  assign bus.mem_valid   = mem_valid_w;
  assign bus.m_alu_out   = main_q.alu_out;
  assign bus.m_st_data   = main_q.st_data;
  assign bus.m_mem_rd    = main_q.mem_rd;
  assign bus.m_mem_wr    = main_q.mem_wr;
  assign bus.m_rf_we     = main_q.rf_we;
  assign bus.m_halt      = main_q.halt;
  assign bus.m_rf_wsel   = main_q.rf_wsel;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

`ifdef EXMEM_FWD_EN
  // Bypass the head result to decode; loads are excluded since their data
  // is not known until the memory stage completes.
  assign bus.fwd_valid = mem_valid_w && main_q.rf_we && !main_q.mem_rd;
  assign bus.fwd_wsel  = main_q.rf_wsel;
  assign bus.fwd_data  = main_q.alu_out;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_wsel  = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  localparam int WIDTH = 16;
  localparam int REGW  = 3;

  logic clk;
  logic rst_n;

  ex_mem_stage_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();

  ex_mem_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] alu_out;
    logic [15:0] st_data;
    logic        mem_rd;
    logic        mem_wr;
    logic        rf_we;
    logic        halt;
    logic [2:0]  rf_wsel;
  } ent_t;

  ent_t        mq[$];
  logic        m_redir;
  logic [15:0] m_pc;

  function automatic logic branch_taken(input logic [2:0] c, input logic msb, input logic zero);
    case (c)
      3'd1:    return zero;
      3'd2:    return !zero;
      3'd3:    return msb;
      3'd4:    return !msb;
      3'd5:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    m_redir = 1'b0;
    m_pc    = 16'h0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_redir = 1'b0;
      m_pc    = 16'h0;
    end else if (bus.flush) begin
      mq.delete();
      m_redir = 1'b0;
    end else begin
      bit   acc;
      bit   ret;
      logic nr;
      ent_t e;
      acc = bus.ex_valid && (mq.size() < 2);
      ret = (mq.size() > 0) && bus.mem_ready;
      if (ret) void'(mq.pop_front());
      nr = 1'b0;
      if (acc && !m_redir) begin
        e.alu_out = bus.alu_out;
        e.st_data = bus.st_data;
        e.mem_rd  = bus.mem_rd;
        e.mem_wr  = bus.mem_wr;
        e.rf_we   = bus.rf_we;
        e.halt    = bus.halt;
        e.rf_wsel = bus.rf_wsel;
        mq.push_back(e);
        if (branch_taken(bus.br_cond, bus.alu_msb, bus.alu_zero)) begin
          nr   = 1'b1;
          m_pc = bus.br_target;
        end
      end
      m_redir = nr;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    ent_t h;
    logic ev;
    chk("mem_valid", {31'd0, bus.mem_valid}, {31'd0, mq.size() > 0});
    chk("ex_ready", {31'd0, bus.ex_ready}, {31'd0, mq.size() < 2});
    chk("redirect", {31'd0, bus.redirect}, {31'd0, m_redir});
    if (m_redir) chk("redirect_pc", {16'd0, bus.redirect_pc}, {16'd0, m_pc});
    if (!rst_n) begin
      chk("rst_m_alu_out", {16'd0, bus.m_alu_out}, 32'd0);
      chk("rst_redirect_pc", {16'd0, bus.redirect_pc}, 32'd0);
    end
    if (mq.size() > 0) begin
      h = mq[0];
      chk("m_alu_out", {16'd0, bus.m_alu_out}, {16'd0, h.alu_out});
      chk("m_st_data", {16'd0, bus.m_st_data}, {16'd0, h.st_data});
      chk("m_ctl", {28'd0, bus.m_mem_rd, bus.m_mem_wr, bus.m_rf_we, bus.m_halt},
          {28'd0, h.mem_rd, h.mem_wr, h.rf_we, h.halt});
      chk("m_rf_wsel", {29'd0, bus.m_rf_wsel}, {29'd0, h.rf_wsel});
    end
`ifdef EXMEM_FWD_EN
    ev = (mq.size() > 0) ? (mq[0].rf_we && !mq[0].mem_rd) : 1'b0;
    chk("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, ev});
    if (ev) begin
      chk("fwd_wsel", {29'd0, bus.fwd_wsel}, {29'd0, mq[0].rf_wsel});
      chk("fwd_data", {16'd0, bus.fwd_data}, {16'd0, mq[0].alu_out});
    end
`else
    ev = 1'b0;
    chk("fwd_tied", {12'd0, bus.fwd_valid, bus.fwd_wsel, bus.fwd_data}, {31'd0, ev});
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.ex_valid  = 1'b0;
    bus.alu_out   = 16'h0;
    bus.alu_msb   = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.br_cond   = 3'd0;
    bus.br_target = 16'h0;
    bus.st_data   = 16'h0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.rf_we     = 1'b0;
    bus.halt      = 1'b0;
    bus.rf_wsel   = 3'd0;
  endtask

  task automatic send(input logic [15:0] a, input logic [2:0] c, input logic msb,
                      input logic zero, input logic [15:0] tgt);
    idle();
    bus.ex_valid  = 1'b1;
    bus.alu_out   = a;
    bus.st_data   = a ^ 16'h5A5A;
    bus.br_cond   = c;
    bus.alu_msb   = msb;
    bus.alu_zero  = zero;
    bus.br_target = tgt;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    idle();
    step();
    step();
    chk("reset_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("reset_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    chk("reset_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("reset_fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back flow, no bubbles
    bus.mem_ready = 1'b1;
    send(16'h0001, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    chk("b2b_valid1", {31'd0, bus.mem_valid}, 32'd1);
    chk("b2b_data1", {16'd0, bus.m_alu_out}, 32'h0001);
    send(16'h0002, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    chk("b2b_data2", {16'd0, bus.m_alu_out}, 32'h0002);
    send(16'h0003, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    chk("b2b_data3", {16'd0, bus.m_alu_out}, 32'h0003);
    chk("b2b_valid3", {31'd0, bus.mem_valid}, 32'd1);
    idle();
    step();
    chk("b2b_drain", {31'd0, bus.mem_valid}, 32'd0);

    // Backpressure fills the skid, head holds
    bus.mem_ready = 1'b0;
    send(16'hAAAA, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    chk("bp_head1", {16'd0, bus.m_alu_out}, 32'hAAAA);
    send(16'hBBBB, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    chk("bp_ex_ready_low", {31'd0, bus.ex_ready}, 32'd0);
    chk("bp_head_hold", {16'd0, bus.m_alu_out}, 32'hAAAA);
    idle();
    step();
    chk("bp_head_hold2", {16'd0, bus.m_alu_out}, 32'hAAAA);
    bus.mem_ready = 1'b1;
    step();
    chk("bp_head2", {16'd0, bus.m_alu_out}, 32'hBBBB);
    chk("bp_ex_ready_back", {31'd0, bus.ex_ready}, 32'd1);
    step();
    chk("bp_drain", {31'd0, bus.mem_valid}, 32'd0);

    // Branch decode and wrong-path drop
    send(16'h8000, 3'd3, 1'b1, 1'b0, 16'h0040);
    step();
    chk("bltz_redirect", {31'd0, bus.redirect}, 32'd1);
    chk("bltz_pc", {16'd0, bus.redirect_pc}, 32'h0040);
    chk("bltz_stored", {16'd0, bus.m_alu_out}, 32'h8000);
    send(16'h5555, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    chk("bltz_pulse_end", {31'd0, bus.redirect}, 32'd0);
    chk("wrongpath_dropped", {31'd0, bus.mem_valid}, 32'd0);
    send(16'h0007, 3'd1, 1'b0, 1'b0, 16'h0080);
    step();
    chk("beqz_not_taken", {31'd0, bus.redirect}, 32'd0);
    chk("beqz_stored", {31'd0, bus.mem_valid}, 32'd1);
    idle();
    step();

    // Flush priority from FULL
    bus.mem_ready = 1'b0;
    send(16'h0011, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    send(16'h0022, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    chk("flush_full", {31'd0, bus.ex_ready}, 32'd0);
    send(16'h0033, 3'd5, 1'b0, 1'b0, 16'h0100);
    bus.flush     = 1'b1;
    bus.mem_ready = 1'b1;
    step();
    chk("flush_empty", {31'd0, bus.mem_valid}, 32'd0);
    chk("flush_no_redirect", {31'd0, bus.redirect}, 32'd0);
    bus.flush = 1'b0;
    idle();
    step();
    chk("flush_stays_empty", {31'd0, bus.mem_valid}, 32'd0);

    // Forwarding from the head register
    bus.mem_ready = 1'b0;
    send(16'h1234, 3'd0, 1'b0, 1'b0, 16'h0);
    bus.rf_we   = 1'b1;
    bus.rf_wsel = 3'd3;
    step();
`ifdef EXMEM_FWD_EN
    chk("fwd_valid_alu", {31'd0, bus.fwd_valid}, 32'd1);
    chk("fwd_wsel_lit", {29'd0, bus.fwd_wsel}, 32'd3);
    chk("fwd_data_lit", {16'd0, bus.fwd_data}, 32'h1234);
`else
    chk("fwd_off_zero", {12'd0, bus.fwd_valid, bus.fwd_wsel, bus.fwd_data}, 32'd0);
`endif
    bus.mem_ready = 1'b1;
    bus.mem_rd    = 1'b1;
    step();
    chk("fwd_load_blocked", {31'd0, bus.fwd_valid}, 32'd0);
    idle();
    step();
    step();

    // Asynchronous reset in FULL with a redirect pending
    bus.mem_ready = 1'b0;
    send(16'h0101, 3'd0, 1'b0, 1'b0, 16'h0);
    step();
    send(16'h0202, 3'd5, 1'b0, 1'b0, 16'h0200);
    step();
    chk("pre_rst_full", {31'd0, bus.ex_ready}, 32'd0);
    chk("pre_rst_redirect", {31'd0, bus.redirect}, 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("async_rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("async_rst_m_alu_out", {16'd0, bus.m_alu_out}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    chk("post_rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);

    // Randomized traffic, checked each cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.ex_valid  = ($urandom_range(0, 9) < 7);
      bus.mem_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.alu_out   = 16'($urandom);
      bus.alu_msb   = 1'($urandom);
      bus.alu_zero  = 1'($urandom);
      bus.br_cond   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      bus.br_target = 16'($urandom);
      bus.st_data   = 16'($urandom);
      bus.mem_rd    = 1'($urandom);
      bus.mem_wr    = 1'($urandom);
      bus.rf_we     = 1'($urandom);
      bus.halt      = ($urandom_range(0, 15) == 0);
      bus.rf_wsel   = 3'($urandom);
    end
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
